// File: rtl/mesh_switch_buffered_if.sv
// Bus bundle for mesh_switch_buffered.
// Upstream side : i_sel, i_valid, i_data (into the switch), o_ready (back out).
// Downstream side: o_valid, o_data (out of the switch), i_ready (back in).
// Status        : o_error (sticky), o_count (delivered flits per output).
// The switch connects through the slave modport; the driver/observer uses master.
interface mesh_switch_buffered_if #(
  parameter int RADIX      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [0:RADIX-1][0:RADIX-1]      i_sel;
  logic [0:RADIX-1]                 i_valid;
  logic [0:RADIX-1][DATA_WIDTH-1:0] i_data;
  logic [0:RADIX-1]                 o_ready;
  logic [0:RADIX-1]                 o_valid;
  logic [0:RADIX-1][DATA_WIDTH-1:0] o_data;
  logic [0:RADIX-1]                 i_ready;
  logic                             o_error;
  logic [0:RADIX-1][CNT_WIDTH-1:0]  o_count;

  modport master (
    output i_sel, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_error, o_count
  );

  modport slave (
    input  i_sel, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_error, o_count
  );
endinterface

// File: rtl/mesh_switch_buffered.sv
// RADIX x RADIX crossbar with a 2-entry output buffer per port.
// Ports:
//   clk     : clock
//   reset_n : synchronous, active-low reset
//   bus     : mesh_switch_buffered_if.slave (select/valid/data in, ready out;
//             valid/data out, ready in; sticky error; per-output counters)
// Each input carries a onehot output select. Lowest-index requester wins an
// output; any conflict or multi-bit select raises the sticky error flag.
// o_ready depends only on the inputs and registered occupancy, never on i_ready.
module mesh_switch_buffered #(
  parameter int RADIX      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  mesh_switch_buffered_if.slave bus
);

  logic [0:RADIX-1][1:0]            occ_q, occ_d;
  logic [0:RADIX-1][DATA_WIDTH-1:0] head_q, head_d;
  logic [0:RADIX-1][DATA_WIDTH-1:0] tail_q, tail_d;
  logic [0:RADIX-1][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                             error_q, error_d;

  logic [0:RADIX-1]                 sel_onehot;
  logic [0:RADIX-1]                 sel_multi;
  logic [0:RADIX-1]                 space;
  logic [0:RADIX-1]                 push;
  logic [0:RADIX-1]                 pop;
  logic [0:RADIX-1][0:RADIX-1]      grant;      // grant[n][o]: input n won output o
  logic [0:RADIX-1][DATA_WIDTH-1:0] push_data;
  logic [0:RADIX-1]                 sel_v;
  logic                             found;
  logic                             conflict_any;
  logic                             illegal_any;

  // Select decode: a nonzero select with no other bits after clearing the
  // lowest set bit is onehot; anything else nonzero is illegal.
  always_comb begin
    sel_onehot  = '0;
    sel_multi   = '0;
    sel_v       = '0;
    illegal_any = 1'b0;
    for (int n = 0; n < RADIX; n++) begin
      sel_v         = bus.i_sel[n];
      sel_onehot[n] = (sel_v != '0) && ((sel_v & (sel_v - RADIX'(1))) == '0);
      sel_multi[n]  = (sel_v != '0) && !sel_onehot[n];
      if (bus.i_valid[n] && sel_multi[n]) illegal_any = 1'b1;
    end
  end

  // Per-output fixed-priority pick; a second requester is a conflict.
  always_comb begin
    grant        = '0;
    push_data    = '0;
    push         = '0;
    space        = '0;
    found        = 1'b0;
    conflict_any = 1'b0;
    for (int o = 0; o < RADIX; o++) begin
      found    = 1'b0;
      space[o] = (occ_q[o] != 2'd2);
      for (int n = 0; n < RADIX; n++) begin
        if (bus.i_valid[n] && sel_onehot[n] && bus.i_sel[n][o]) begin
          if (!found) begin
            grant[n][o]  = 1'b1;
            push_data[o] = bus.i_data[n];
            found        = 1'b1;
          end else begin
            conflict_any = 1'b1;
          end
        end
      end
      push[o] = found && space[o];
    end
  end

  always_comb begin
    bus.o_ready = '0;
    for (int n = 0; n < RADIX; n++) begin
      bus.o_ready[n] = reset_n && ((grant[n] & space) != '0);
    end
  end

  // Output buffers: head_q is the visible entry, tail_q the second slot.
  // Push with pop only happens at occupancy 1, so the new flit becomes head.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    pop    = '0;
    for (int o = 0; o < RADIX; o++) begin
      pop[o] = (occ_q[o] != 2'd0) && bus.i_ready[o];
      case ({push[o], pop[o]})
        2'b10: begin
          if (occ_q[o] == 2'd0) begin
            head_d[o] = push_data[o];
            occ_d[o]  = 2'd1;
          end else begin
            tail_d[o] = push_data[o];
            occ_d[o]  = 2'd2;
          end
        end
        2'b01: begin
          if (occ_q[o] == 2'd2) begin
            head_d[o] = tail_q[o];
            occ_d[o]  = 2'd1;
          end else begin
            occ_d[o]  = 2'd0;
          end
        end
        2'b11: begin
          head_d[o] = push_data[o];
        end
        default: ;
      endcase
      if (pop[o]) cnt_d[o] = cnt_q[o] + CNT_WIDTH'(1);
    end
    error_d = error_q || illegal_any || conflict_any;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    bus.o_valid = '0;
    for (int o = 0; o < RADIX; o++) begin
      bus.o_valid[o] = (occ_q[o] != 2'd0);
    end
  end

  assign bus.o_data  = head_q;
  assign bus.o_count = cnt_q;
  assign bus.o_error = error_q;

endmodule

// File: tb/tb_mesh_switch_buffered.sv
module tb_mesh_switch_buffered;
  localparam int RADIX = 5;
  localparam int DW    = 32;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [0:RADIX-1]          ev;
  logic [0:RADIX-1][CW-1:0]  ec;

  mesh_switch_buffered_if #(.RADIX(RADIX), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  mesh_switch_buffered #(.RADIX(RADIX), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_valid = '0;
    bus.i_sel   = '0;
    bus.i_data  = '0;
  endtask

  task automatic drive(input int n, input int o, input logic [DW-1:0] d);
    bus.i_valid[n] = 1'b1;
    bus.i_sel[n]   = '0;
    bus.i_sel[n][o] = 1'b1;
    bus.i_data[n]  = d;
  endtask

  function automatic logic [0:RADIX-1] bit_at(input int i);
    logic [0:RADIX-1] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    chk("rst_valid", bus.o_valid, '0);
    chk("rst_count", bus.o_count, '0);
    chk("rst_error", bus.o_error, 0);
    chk("rst_ready", bus.o_ready, '0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    bus.i_ready = '1;
    // o_ready must stay low during reset even with a legal request
    drive(0, 0, 32'h1);
    tick();
    tick();
    chk("rst_ready_forced", bus.o_ready, '0);
    chk("rst_data", bus.o_data, '0);
    chk("rst_valid0", bus.o_valid, '0);
    chk("rst_error0", bus.o_error, 0);
    clear_inputs();
    reset_n = 1'b1;
    tick();

    // Sweep every input to every output
    for (int n = 0; n < RADIX; n++) begin
      for (int o = 0; o < RADIX; o++) begin
        clear_inputs();
        drive(n, o, DW'(n * 16 + o));
        #1;
        chk("sweep_ready", bus.o_ready, bit_at(n));
        tick();
        chk("sweep_valid", bus.o_valid, bit_at(o));
        chk("sweep_data", bus.o_data[o], n * 16 + o);
      end
    end
    clear_inputs();
    tick();
    for (int o = 0; o < RADIX; o++) ec[o] = 4'd5;
    chk("sweep_count", bus.o_count, ec);
    chk("sweep_error", bus.o_error, 0);
    chk("sweep_idle", bus.o_valid, '0);

    // Backpressure on output 2
    bus.i_ready[2] = 1'b0;
    drive(0, 2, 32'hA);
    #1;
    chk("bp_ready_a", bus.o_ready[0], 1);
    tick();
    drive(0, 2, 32'hB);
    #1;
    chk("bp_ready_b", bus.o_ready[0], 1);
    chk("bp_valid_a", bus.o_valid[2], 1);
    chk("bp_head_a", bus.o_data[2], 32'hA);
    tick();
    drive(0, 2, 32'hC);
    #1;
    chk("bp_ready_full", bus.o_ready[0], 0);
    tick();
    chk("bp_ready_hold", bus.o_ready[0], 0);
    chk("bp_head_hold", bus.o_data[2], 32'hA);
    bus.i_ready[2] = 1'b1;
    tick();
    chk("bp_head_b", bus.o_data[2], 32'hB);
    chk("bp_ready_again", bus.o_ready[0], 1);
    tick();
    clear_inputs();
    chk("bp_head_c", bus.o_data[2], 32'hC);
    chk("bp_valid_c", bus.o_valid[2], 1);
    tick();
    chk("bp_drained", bus.o_valid[2], 0);
    chk("bp_count", bus.o_count[2], 8);

    // Conflict on output 4
    drive(1, 4, 32'h11);
    drive(3, 4, 32'h33);
    #1;
    chk("cf_ready", bus.o_ready, bit_at(1));
    chk("cf_err_pre", bus.o_error, 0);
    tick();
    clear_inputs();
    chk("cf_data", bus.o_data[4], 32'h11);
    chk("cf_error", bus.o_error, 1);
    tick();
    chk("cf_error_sticky", bus.o_error, 1);
    chk("cf_drained", bus.o_valid, '0);
    chk("cf_count", bus.o_count[4], 6);

    // Zero select then illegal select
    do_reset();
    bus.i_valid[0] = 1'b1;
    bus.i_sel[0]   = '0;
    bus.i_data[0]  = 32'h77;
    #1;
    chk("zsel_ready", bus.o_ready[0], 0);
    tick();
    chk("zsel_error", bus.o_error, 0);
    chk("zsel_valid", bus.o_valid, '0);
    bus.i_sel[0] = 5'b01100;
    #1;
    chk("ill_ready", bus.o_ready[0], 0);
    tick();
    clear_inputs();
    chk("ill_error", bus.o_error, 1);
    chk("ill_valid", bus.o_valid, '0);

    // Counter wrap: 17 flits to output 0 with a 4-bit counter
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(0, 0, DW'(k));
      tick();
    end
    clear_inputs();
    chk("wrap_last", bus.o_data[0], 16);
    tick();
    ec    = '0;
    ec[0] = 4'd1;
    chk("wrap_count", bus.o_count, ec);

    // Reset while buffer 3 holds two flits
    do_reset();
    bus.i_ready[3] = 1'b0;
    drive(1, 3, 32'hD1);
    tick();
    drive(1, 3, 32'hD2);
    tick();
    clear_inputs();
    chk("mr_full_valid", bus.o_valid[3], 1);
    drive(2, 0, 32'h99);
    reset_n = 1'b0;
    #1;
    chk("mr_ready_forced", bus.o_ready, '0);
    tick();
    chk("mr_valid", bus.o_valid, '0);
    chk("mr_count", bus.o_count, '0);
    chk("mr_error", bus.o_error, 0);
    chk("mr_ready", bus.o_ready, '0);
    reset_n = 1'b1;
    bus.i_ready = '1;
    clear_inputs();
    drive(2, 0, 32'h5A);
    #1;
    chk("mr_new_ready", bus.o_ready, bit_at(2));
    tick();
    clear_inputs();
    chk("mr_new_valid", bus.o_valid, bit_at(0));
    chk("mr_new_data", bus.o_data[0], 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
